// File: rtl/rx_boxcar_decimator.sv
// Boxcar decimator: sums N complex I/Q samples per result and queues results in a small FIFO.
// Define RX_DECIM_OVF_EN to get a sticky overflow_o flag for results dropped on a full FIFO.
module rx_boxcar_decimator #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] rate_axis_tdata_i,
    input  logic        rate_axis_tvalid_i,
    input  logic [31:0] rx_iq_axis_tdata_i,
    input  logic        rx_iq_axis_tvalid_i,
    output logic [63:0] axis_tdata_o,
    output logic        axis_tvalid_o,
    input  logic        axis_tready_i,
    output logic        overflow_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [15:0] r_rate;
    logic [15:0] r_count;
    logic [31:0] r_accI;
    logic [31:0] r_accQ;
    logic [63:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wrPtr;
    logic [AW:0] r_rdPtr;

    logic        w_accept;
    logic        w_last;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_write;
    logic [31:0] w_sumI;
    logic [31:0] w_sumQ;

    // A rate load in the same cycle wins over the sample, and R=0 parks the accumulator.
    assign w_accept = rx_iq_axis_tvalid_i && !rate_axis_tvalid_i && (r_rate != 16'd0);
    assign w_last   = w_accept && (r_count == r_rate - 16'd1);
    assign w_sumI   = r_accI + {{16{rx_iq_axis_tdata_i[15]}}, rx_iq_axis_tdata_i[15:0]};
    assign w_sumQ   = r_accQ + {{16{rx_iq_axis_tdata_i[31]}}, rx_iq_axis_tdata_i[31:16]};

    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_pop   = !w_empty && axis_tready_i;
    assign w_write = w_last && (!w_full || w_pop);

    assign axis_tvalid_o = !w_empty;
    assign axis_tdata_o  = w_empty ? 64'd0 : r_mem[r_rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rate  <= 16'd0;
            r_count <= 16'd0;
            r_accI  <= 32'd0;
            r_accQ  <= 32'd0;
        end else if (rate_axis_tvalid_i) begin
            r_rate  <= rate_axis_tdata_i;
            r_count <= 16'd0;
            r_accI  <= 32'd0;
            r_accQ  <= 32'd0;
        end else if (w_accept) begin
            if (w_last) begin
                r_count <= 16'd0;
                r_accI  <= 32'd0;
                r_accQ  <= 32'd0;
            end else begin
                r_count <= r_count + 16'd1;
                r_accI  <= w_sumI;
                r_accQ  <= w_sumQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_write) r_wrPtr <= r_wrPtr + {{AW{1'b0}}, 1'b1};
            if (w_pop)   r_rdPtr <= r_rdPtr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage needs no reset: the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_write) r_mem[r_wrPtr[AW-1:0]] <= {w_sumQ, w_sumI};
    end

`ifdef RX_DECIM_OVF_EN
    logic r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (rate_axis_tvalid_i) begin
            r_overflow <= 1'b0;
        end else if (w_last && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow_o = r_overflow;
`else
    assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_rx_boxcar_decimator.sv
// Self-checking bench for rx_boxcar_decimator: directed cases with literal results plus
// randomized traffic compared every cycle against a queue-based behavioural model.
module tb_rx_boxcar_decimator;
    localparam int DEPTH = 4;
`ifdef RX_DECIM_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rateData = 16'd0;
    logic        rateValid = 1'b0;
    logic [31:0] rxData = 32'd0;
    logic        rxValid = 1'b0;
    logic [63:0] outData;
    logic        outValid;
    logic        outReady = 1'b0;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    // Behavioural model: running sums, a sample count, and a queue standing in for the FIFO.
    int          mRate = 0;
    int          mCount = 0;
    int          mSumI = 0;
    int          mSumQ = 0;
    logic [63:0] mFifo[$];
    bit          mOvf = 1'b0;
    bit          mJustReset = 1'b0;
    bit          modelReady = 1'b0;

    rx_boxcar_decimator #(.FIFO_DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rate_axis_tdata_i   (rateData),
        .rate_axis_tvalid_i  (rateValid),
        .rx_iq_axis_tdata_i  (rxData),
        .rx_iq_axis_tvalid_i (rxValid),
        .axis_tdata_o        (outData),
        .axis_tvalid_o       (outValid),
        .axis_tready_i       (outReady),
        .overflow_o          (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs, then returns at the following falling edge.
    task automatic applyStimulus(input logic rstV, input logic rateV, input logic [15:0] rate,
                                 input logic rxV, input logic [15:0] iVal, input logic [15:0] qVal,
                                 input logic rdy);
        rst       = rstV;
        rateValid = rateV;
        rateData  = rate;
        rxValid   = rxV;
        rxData    = {qVal, iVal};
        outReady  = rdy;
        @(negedge clk);
    endtask

    // Model update: what the block must do at each rising edge, from the sampled inputs.
    initial forever begin : modelProc
        bit          doPop;
        bit          doPush;
        bit          dropped;
        logic [63:0] val;
        @(posedge clk);
        if (rst) begin
            mRate = 0; mCount = 0; mSumI = 0; mSumQ = 0;
            mFifo.delete();
            mOvf = 1'b0;
            mJustReset = 1'b1;
            modelReady = 1'b1;
        end else begin
            mJustReset = 1'b0;
            doPop  = outReady && (mFifo.size() != 0);
            doPush = 1'b0;
            val    = 64'd0;
            if (rateValid) begin
                mRate = int'(rateData);
                mCount = 0; mSumI = 0; mSumQ = 0;
                mOvf = 1'b0;
            end else if (rxValid && mRate != 0) begin
                mSumI += $signed(rxData[15:0]);
                mSumQ += $signed(rxData[31:16]);
                mCount++;
                if (mCount == mRate) begin
                    val = {mSumQ, mSumI};
                    doPush = 1'b1;
                    mCount = 0; mSumI = 0; mSumQ = 0;
                end
            end
            dropped = doPush && (mFifo.size() == DEPTH) && !doPop;
            if (dropped) mOvf = 1'b1;
            if (doPop) void'(mFifo.pop_front());
            if (doPush && !dropped) mFifo.push_back(val);
        end
    end

    // Every falling edge: DUT outputs must match the model's view of the FIFO and flag.
    initial forever begin
        @(negedge clk);
        if (modelReady) begin
            checkOutput("tvalid", {63'd0, outValid}, {63'd0, mFifo.size() != 0});
            if (mFifo.size() != 0) checkOutput("tdata", outData, mFifo[0]);
            else if (mJustReset) checkOutput("tdataAfterReset", outData, 64'd0);
            checkOutput("overflow", {63'd0, overflow}, {63'd0, OVF_EN & mOvf});
        end
    end

    initial begin
        logic [63:0] expWord;
        logic        rdy;

        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("resetTvalid", {63'd0, outValid}, 64'd0);
        checkOutput("resetTdata", outData, 64'd0);
        checkOutput("resetOverflow", {63'd0, overflow}, 64'd0);

        // R=4, I=1..4, Q=-1: one result {Q=-4, I=10}, valid for exactly one cycle.
        applyStimulus(0, 1, 16'd4, 0, 0, 0, 1);
        for (int k = 1; k <= 3; k++) applyStimulus(0, 0, 0, 1, 16'(k), 16'hFFFF, 1);
        checkOutput("r4Early", {63'd0, outValid}, 64'd0);
        applyStimulus(0, 0, 0, 1, 16'd4, 16'hFFFF, 1);
        checkOutput("r4Valid", {63'd0, outValid}, 64'd1);
        checkOutput("r4Data", outData, {32'hFFFFFFFC, 32'h0000000A});
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("r4OneCycle", {63'd0, outValid}, 64'd0);

        // R=1 passes each sample through sign-extended.
        applyStimulus(0, 1, 16'd1, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 1, 16'h8000, 16'h7FFF, 1);
            checkOutput("r1Data", outData, {32'h00007FFF, 32'hFFFF8000});
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // R=0 discards everything.
        applyStimulus(0, 1, 16'd0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 1, 16'd7, 16'd7, 1);
        checkOutput("r0NoOutput", {63'd0, outValid}, 64'd0);

        // Fill a stalled FIFO past capacity, then drain in order.
        applyStimulus(0, 1, 16'd1, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) applyStimulus(0, 0, 0, 1, 16'(k), 16'(-k), 0);
        checkOutput("ovfSet", {63'd0, overflow}, {63'd0, OVF_EN});
        for (int k = 1; k <= 4; k++) begin
            expWord = {32'(-k), 32'(k)};
            checkOutput("drainValid", {63'd0, outValid}, 64'd1);
            checkOutput("drainOrder", outData, expWord);
            applyStimulus(0, 0, 0, 0, 0, 0, 1);
        end
        checkOutput("drainEmpty", {63'd0, outValid}, 64'd0);
        checkOutput("ovfSticky", {63'd0, overflow}, {63'd0, OVF_EN});
        applyStimulus(0, 1, 16'd4, 0, 0, 0, 1);
        checkOutput("ovfClearedByLoad", {63'd0, overflow}, 64'd0);

        // Rate reload discards the partial sum and the coincident sample.
        applyStimulus(0, 0, 0, 1, 16'd100, 16'd0, 1);
        applyStimulus(0, 0, 0, 1, 16'd200, 16'd0, 1);
        applyStimulus(0, 1, 16'd2, 1, 16'd1000, 16'd1000, 1);
        applyStimulus(0, 0, 0, 1, 16'd3, 16'd7, 1);
        checkOutput("reloadEarly", {63'd0, outValid}, 64'd0);
        applyStimulus(0, 0, 0, 1, 16'd4, 16'd8, 1);
        checkOutput("reloadData", outData, {32'd15, 32'd7});
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // Reset mid-accumulation leaves no residue.
        applyStimulus(0, 1, 16'd3, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 16'd9, 16'd9, 1);
        applyStimulus(0, 0, 0, 1, 16'd9, 16'd9, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        checkOutput("midResetTvalid", {63'd0, outValid}, 64'd0);
        applyStimulus(0, 1, 16'd3, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 1, 16'd5, 16'd0, 1);
        checkOutput("midResetData", outData, {32'd0, 32'd15});
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // Largest rate with the most negative samples must not wrap.
        applyStimulus(0, 1, 16'hFFFF, 0, 0, 0, 1);
        for (int k = 0; k < 65534; k++) applyStimulus(0, 0, 0, 1, 16'h8000, 16'h8000, 1);
        checkOutput("maxRateEarly", {63'd0, outValid}, 64'd0);
        applyStimulus(0, 0, 0, 1, 16'h8000, 16'h8000, 1);
        checkOutput("maxRateData", outData, {32'h80008000, 32'h80008000});
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // Randomized traffic with alternating mostly-ready and mostly-stalled phases.
        for (int c = 0; c < 4000; c++) begin
            rdy = ((c / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            applyStimulus($urandom_range(0, 499) == 0,
                          $urandom_range(0, 39) == 0,
                          16'($urandom_range(0, 5)),
                          $urandom_range(0, 9) < 7,
                          16'($urandom), 16'($urandom),
                          rdy);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rx_boxcar_decimator.md
RX_BOXCAR_DECIMATOR -- requirements
Module: rx_boxcar_decimator

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port rate_axis_tdata_i  in  16  decimation factor N, unsigned.
REQ-005 SHALL have port rate_axis_tvalid_i  in  1  loads rate_axis_tdata_i; no tready.
REQ-006 SHALL have port rx_iq_axis_tdata_i  in  32  input sample {Q[31:16], I[15:0]}, both two's complement.
REQ-007 SHALL have port rx_iq_axis_tvalid_i  in  1  sample strobe; no tready, always accepted.
REQ-008 SHALL have port axis_tdata_o  out  64  result {Qsum[63:32], Isum[31:0]}, two's complement.
REQ-009 SHALL have port axis_tvalid_o  out  1  FIFO non-empty.
REQ-010 SHALL have port axis_tready_i  in  1  downstream accept; a transfer occurs when axis_tvalid_o and axis_tready_i are both high.
REQ-011 SHALL have port overflow_o  out  1  sticky flag: a result was dropped.

Function
REQ-012 SHALL hold rate register R, I/Q accumulators (32 b each), sample counter (16 b) and a FIFO_DEPTH x 64 b FIFO.
REQ-013 SHALL load R from rate_axis_tdata_i, clear both accumulators and the counter, and clear overflow_o on any cycle with rate_axis_tvalid_i high.
REQ-014 SHALL discard any rx_iq sample arriving in the same cycle as a rate load.
REQ-015 With R=0, SHALL discard all samples and produce no results; FIFO contents SHALL still drain normally.
REQ-016 With R>=1, SHALL add each accepted sample's I and Q, sign-extended 16->32, to the accumulators and increment the counter.
REQ-017 On the Nth accepted sample (counter = R-1), SHALL push {acc_Q+Q, acc_I+I} to the FIFO, zero the accumulators and zero the counter in the same edge.
REQ-018 Width rule: 65535 x +/-32768 fits in 32 b signed, so the sum SHALL NOT wrap; no saturation logic.
REQ-019 Latency: axis_tvalid_o SHALL rise on the cycle after the edge that samples the Nth input when the FIFO was empty.
REQ-020 R=1 SHALL yield one result per input sample, equal to the sign-extended input.
REQ-021 FIFO SHALL be first-in first-out; axis_tdata_o SHALL show the head entry and remain stable while axis_tvalid_o is high and axis_tready_i is low.
REQ-022 Push while full with no pop in the same cycle: SHALL drop the new result, keep the FIFO unchanged, and set overflow_o.
REQ-023 Push while full with a pop in the same cycle: SHALL accept the push; level unchanged; no overflow.
REQ-024 Pop while empty SHALL have no effect.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-026 With rst high at a clock edge: R=0, accumulators=0, counter=0, FIFO empty, axis_tvalid_o=0, axis_tdata_o=0, overflow_o=0.
REQ-027 Reset during accumulation or with FIFO entries pending SHALL discard the partial sum and all entries; rst SHALL take priority over every other input.

Configuration
REQ-028 Macro RX_DECIM_OVF_EN: when defined, overflow_o SHALL behave as in REQ-013, REQ-022 and REQ-026.
REQ-029 When RX_DECIM_OVF_EN is undefined, overflow_o SHALL be tied to 0 and no flag register SHALL exist; drop behaviour SHALL be unchanged.

Verification
REQ-030 Load R=4, axis_tready_i=1, inputs I=1,2,3,4 Q=-1 every cycle -> one output {Q=-4, I=10}; axis_tvalid_o high for 1 cycle, 1 cycle after the 4th sample.
REQ-031 Load R=1, inputs I=-32768 Q=32767 -> axis_tdata_o = {32'h00007FFF, 32'hFFFF8000} each cycle.
REQ-032 Load R=65535, feed 65535 samples of I=Q=-32768 -> Isum = Qsum = -2147450880, with no wrap.
REQ-033 Load R=1, axis_tready_i=0, send 5 samples with FIFO_DEPTH=4 -> 4 entries held, the 5th dropped, overflow_o=1 (0 when the macro is undefined); then tready=1 -> samples 1..4 drained in order.
REQ-034 Load R=4, send 2 samples, load R=2 with a sample in the same cycle -> that sample discarded; the next 2 samples alone form the output.
REQ-035 Load R=3, send 2 samples, pulse rst, load R=3, send 3 samples of I=5 -> single output Isum=15, with no residue from before reset.
